// File: rtl/flash_reader_pkg.sv
// Shared constants, FSM state type and helpers for the serial NOR flash bulk reader.
package flash_reader_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;
  localparam int         WORD_BITS = 32;

  localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
  localparam logic [4:0] WORD_LAST = 5'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMMAND = 3'd1,
    ST_ADDRESS = 3'd2,
    ST_DATA    = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  // Flash delivers b0 first; the stream wants b0 in the least significant byte.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_reader.sv
// SPI mode-0 master issuing READ (0x03) to a NOR flash and streaming the
// returned bytes as 32-bit little-endian words with valid/ready backpressure.
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int COUNT_BITWIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [23:0]               start_address,
  input  logic [COUNT_BITWIDTH-1:0] word_count,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      flash_clk,
  output logic                      flash_cs_n,
  output logic                      flash_mosi,
  input  logic                      flash_miso
);

  localparam logic [COUNT_BITWIDTH-1:0] ONE_WORD = COUNT_BITWIDTH'(1);

  state_e                      state_r, state_next_s;
  logic [4:0]                  bit_cnt_r;
  logic [COUNT_BITWIDTH-1:0]   words_left_r;
  logic [31:0]                 shift_out_r;
  logic [30:0]                 shift_in_r;
  logic [31:0]                 data_out_r;
  logic                        flash_clk_r, flash_cs_n_r, flash_mosi_r;
  logic                        busy_r, done_r, data_valid_r;

  logic active_s, stall_s, rise_s, fall_s, accept_s;
  logic launch_s, empty_start_s, bit_last_s, word_done_s, finish_s;

  // Next-state decode plus the per-cycle SPI phase strobes.
  always_comb begin
    state_next_s  = state_r;
    active_s      = 1'b0;
    stall_s       = 1'b0;
    launch_s      = 1'b0;
    empty_start_s = 1'b0;
    bit_last_s    = 1'b0;
    finish_s      = 1'b0;
    accept_s      = data_valid_r && data_ready;
    case (state_r)
      ST_IDLE: begin
        if (start && (word_count != {COUNT_BITWIDTH{1'b0}})) begin
          launch_s     = 1'b1;
          state_next_s = ST_COMMAND;
        end else if (start) begin
          empty_start_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_COMMAND: begin
        active_s   = 1'b1;
        bit_last_s = (bit_cnt_r == CMD_LAST);
        if (flash_clk_r && bit_last_s) begin
          state_next_s = ST_ADDRESS;
        end else begin
          state_next_s = ST_COMMAND;
        end
      end
      ST_ADDRESS: begin
        active_s   = 1'b1;
        bit_last_s = (bit_cnt_r == ADDR_LAST);
        if (flash_clk_r && bit_last_s) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_ADDRESS;
        end
      end
      ST_DATA: begin
        active_s   = 1'b1;
        // A new word may not clock in while the previous one is still unconsumed.
        stall_s    = (bit_cnt_r == 5'd0) && data_valid_r && !data_ready;
        bit_last_s = (bit_cnt_r == WORD_LAST);
        if (flash_clk_r && bit_last_s && (words_left_r == ONE_WORD)) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_FINISH: begin
        if (accept_s) begin
          finish_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FINISH;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    rise_s      = active_s && !flash_clk_r && !stall_s;
    fall_s      = active_s && flash_clk_r;
    word_done_s = fall_s && (state_r == ST_DATA) && bit_last_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // SPI shifters, word assembly, stream handshake and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r    <= 5'd0;
      words_left_r <= {COUNT_BITWIDTH{1'b0}};
      shift_out_r  <= 32'd0;
      shift_in_r   <= 31'd0;
      data_out_r   <= 32'd0;
      flash_clk_r  <= 1'b0;
      flash_cs_n_r <= 1'b1;
      flash_mosi_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      data_valid_r <= 1'b0;
    end else begin
      done_r <= empty_start_s || finish_s;
      if (launch_s) begin
        busy_r       <= 1'b1;
        flash_cs_n_r <= 1'b0;
        flash_clk_r  <= 1'b0;
        flash_mosi_r <= CMD_READ[7];
        shift_out_r  <= {CMD_READ[6:0], start_address, 1'b0};
        words_left_r <= word_count;
        bit_cnt_r    <= 5'd0;
      end else if (rise_s) begin
        flash_clk_r <= 1'b1;
      end else if (fall_s) begin
        // Zeros shifted in behind the address keep MOSI low during DATA.
        flash_clk_r  <= 1'b0;
        flash_mosi_r <= shift_out_r[31];
        shift_out_r  <= {shift_out_r[30:0], 1'b0};
        shift_in_r   <= {shift_in_r[29:0], flash_miso};
        bit_cnt_r    <= bit_last_s ? 5'd0 : (bit_cnt_r + 5'd1);
        if (word_done_s) begin
          data_out_r   <= byte_swap({shift_in_r, flash_miso});
          words_left_r <= words_left_r - ONE_WORD;
          if (words_left_r == ONE_WORD) begin
            flash_cs_n_r <= 1'b1;
          end
        end
      end
      if (word_done_s) begin
        data_valid_r <= 1'b1;
      end else if (accept_s) begin
        data_valid_r <= 1'b0;
      end
      if (finish_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign flash_clk  = flash_clk_r;
  assign flash_cs_n = flash_cs_n_r;
  assign flash_mosi = flash_mosi_r;

endmodule

// File: tb/tb_flash_reader.sv
// Self-checking bench for flash_reader: behavioural SPI flash, table-driven and
// randomized reads checked against word expectations built from flash contents.
module tb_flash_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] start_address;
  logic [15:0] word_count;
  logic        busy, done, data_valid, data_ready;
  logic [31:0] data_out;
  logic        flash_clk, flash_cs_n, flash_mosi, flash_miso;

  int checks = 0;
  int errors = 0;

  flash_reader #(.COUNT_BITWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_address(start_address),
    .word_count(word_count), .busy(busy), .done(done), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .flash_clk(flash_clk),
    .flash_cs_n(flash_cs_n), .flash_mosi(flash_mosi), .flash_miso(flash_miso)
  );

  always #5 clk = ~clk;

  // Flash contents: byte at address a is a[7:0].
  logic [7:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
  end

  // Behavioural flash: rising flash_clk samples MOSI, falling edge presents MISO.
  int          fm_bits;
  logic [31:0] fm_head;
  int          fm_k;
  logic [7:0]  fm_byte;
  initial begin
    fm_bits    = 0;
    fm_head    = 32'd0;
    flash_miso = 1'b0;
  end

  always @(posedge flash_clk or negedge flash_cs_n) begin
    if (!flash_clk) begin
      fm_bits = 0;
      fm_head = 32'd0;
    end else if (!flash_cs_n) begin
      if (fm_bits < 32) fm_head = {fm_head[30:0], flash_mosi};
      fm_bits = fm_bits + 1;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_cs_n && fm_bits >= 32) begin
      fm_k       = fm_bits - 32;
      fm_byte    = mem[12'(int'(fm_head[11:0]) + fm_k / 8)];
      flash_miso = fm_byte[7 - (fm_k % 8)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [23:0] addr, input int idx);
    int b;
    b = int'(addr[11:0]) + 4 * idx;
    return {mem[12'(b + 3)], mem[12'(b + 2)], mem[12'(b + 1)], mem[12'(b)]};
  endfunction

  // One complete read; stall = cycles data_ready is held low after each new word.
  task automatic run_read(input logic [23:0] addr, input int n, input int stall,
                          input bit poke, input logic [31:0] exp_first);
    logic [31:0] expw [$];
    logic [31:0] first_word;
    int cyc, got, wait_cnt, accept_cyc, done_cyc, limit;
    logic prev_cs, prev_valid, prev_ready;
    for (int i = 0; i < n; i++) expw.push_back(model_word(addr, i));
    @(negedge clk);
    start = 1'b1; start_address = addr; word_count = 16'(n);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; got = 0; wait_cnt = 0; accept_cyc = -10; done_cyc = 0;
    first_word = 32'd0;
    limit = 200 + n * (70 + stall);
    prev_cs = 1'b1; prev_valid = 1'b0; prev_ready = 1'b0;
    data_ready = (stall == 0);
    check("busy_after_start", 32'(busy), 32'd1);
    while (done_cyc == 0 && cyc < limit) begin
      if (poke && cyc == 40) begin
        start = 1'b1; start_address = 24'h000100; word_count = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) check("cs_low_cycle1", {31'd0, flash_cs_n}, 32'd0);
      if (cyc == 1) check("sck_low_cycle1", {31'd0, flash_clk}, 32'd0);
      if (cyc == 2) check("sck_high_cycle2", {31'd0, flash_clk}, 32'd1);
      if (data_valid && !prev_valid) begin
        if (got == 0) check("first_valid_cycle", 32'(cyc), 32'd129);
        else if (stall == 0) check("word_spacing", 32'(cyc), 32'(129 + 64 * got));
        if (got == n - 1) begin
          check("cs_rise_last_sample", {31'd0, flash_cs_n}, 32'd1);
          check("cs_low_before_last", {31'd0, prev_cs}, 32'd0);
        end
      end
      if (data_valid && prev_valid && !prev_ready)
        check("stall_sck_low", {31'd0, flash_clk}, 32'd0);
      if (data_valid) begin
        if (wait_cnt < stall) begin
          data_ready = 1'b0;
          wait_cnt++;
        end else begin
          data_ready = 1'b1;
          if (got < n) check("word_data", data_out, expw[got]);
          else check("extra_word", 32'(got), 32'(n - 1));
          if (got == 0) first_word = data_out;
          accept_cyc = cyc;
          got++;
          wait_cnt = 0;
        end
      end else begin
        data_ready = (stall == 0);
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
      prev_valid = data_valid; prev_ready = data_ready; prev_cs = flash_cs_n;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    check("done_after_accept", 32'(done_cyc), 32'(accept_cyc + 1));
    check("done_one_cycle", 32'(done), 32'd0);
    check("word_total", 32'(got), 32'(n));
    check("first_word_table", first_word, exp_first);
    check("flash_cmd", {24'd0, fm_head[31:24]}, 32'h03);
    check("flash_addr", {8'd0, fm_head[23:0]}, {8'd0, addr});
    check("flash_clocks", 32'(fm_bits), 32'(32 + 32 * n));
    check("cs_idle_high", {31'd0, flash_cs_n}, 32'd1);
  endtask

  typedef struct {
    logic [23:0] addr;
    int          n;
    int          stall;
    bit          poke;
    logic [31:0] first;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{addr: 24'h000000, n: 1, stall: 0,  poke: 1'b0, first: 32'h03020100};
    vecs[1] = '{addr: 24'h000004, n: 4, stall: 0,  poke: 1'b0, first: 32'h07060504};
    vecs[2] = '{addr: 24'h000010, n: 3, stall: 20, poke: 1'b0, first: 32'h13121110};
    vecs[3] = '{addr: 24'h000008, n: 2, stall: 0,  poke: 1'b1, first: 32'h0B0A0908};

    rst_n = 1'b0; start = 1'b0; start_address = 24'd0; word_count = 16'd0;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, flash_cs_n}, 32'd1);
    check("rst_sck", {31'd0, flash_clk}, 32'd0);
    check("rst_mosi", {31'd0, flash_mosi}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_data", data_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++)
      run_read(vecs[v].addr, vecs[v].n, vecs[v].stall, vecs[v].poke, vecs[v].first);

    // Zero-length request: immediate done, no flash access.
    @(negedge clk);
    start = 1'b1; start_address = 24'h000040; word_count = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done_cycle1", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("zero_cs_high", {31'd0, flash_cs_n}, 32'd1);
      @(negedge clk);
      check("zero_done_pulse", {31'd0, done}, 32'd0);
    end

    // Asynchronous reset in the middle of the address phase.
    start = 1'b1; start_address = 24'h000020; word_count = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_reset_cs_low", {31'd0, flash_cs_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_cs_n", {31'd0, flash_cs_n}, 32'd1);
    check("arst_valid_busy", {30'd0, data_valid, busy}, 32'd0);
    check("arst_sck_mosi", {30'd0, flash_clk, flash_mosi}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_read(24'h000024, 2, 3, 1'b0, 32'h27262524);

    // Randomized reads against the flash-content model.
    for (int r = 0; r < 6; r++) begin
      logic [23:0] ra;
      int rn, rs;
      ra = 24'($urandom_range(0, 4000));
      rn = int'($urandom_range(1, 3));
      rs = int'($urandom_range(0, 4));
      run_read(ra, rn, rs, 1'b0, model_word(ra, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
